// File: rtl/opti_pkg.sv
// Shared fixed-point constants for the opti multiply/accumulate datapath.
package opti_pkg;

    // Q2.14 output samples and Q4.28 multiplier products
    localparam int Q15_FRAC_BITS = 14;
    localparam int Q28_FRAC_BITS = 28;

    // Q2.14 saturation limits
    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

    // Half an output LSB when rounding Q.28 down to Q.14
    localparam int ROUND_HALF = 32'sd1 <<< 13;

    // Q8.28 accumulator holds eight worst-case products without wrap
    localparam int ACC_W_DEFAULT = 36;

endpackage

// File: rtl/opti_round_sat.sv
// Round-half-up requantizer with saturation to a 16-bit signed result.
module opti_round_sat
    import opti_pkg::*;
#(
    parameter int IN_W  = ACC_W_DEFAULT,
    parameter int SHIFT = Q28_FRAC_BITS - Q15_FRAC_BITS
) (
    input  logic signed [IN_W-1:0] sum_q,
    output logic        [15:0]     y_next,
    output logic                   sat
);

    // One extra bit so adding the rounding constant can never wrap
    localparam logic signed [IN_W:0] HALF  = (IN_W+1)'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [IN_W:0] R_MAX = (IN_W+1)'(32'sd32767);
    localparam logic signed [IN_W:0] R_MIN = (IN_W+1)'(-32'sd32768);

    logic signed [IN_W:0] biased_s;
    logic signed [IN_W:0] r_s;

    assign biased_s = {sum_q[IN_W-1], sum_q} + HALF;
    assign r_s      = biased_s >>> SHIFT;

    // Clip the rounded value into the 16-bit signed range
    always_comb begin
        y_next = r_s[15:0];
        sat    = 1'b0;
        if (r_s > R_MAX) begin
            y_next = Q15_MAX;
            sat    = 1'b1;
        end else if (r_s < R_MIN) begin
            y_next = Q15_MIN;
            sat    = 1'b1;
        end else begin
            y_next = r_s[15:0];
            sat    = 1'b0;
        end
    end

endmodule

// File: rtl/opti_product_accumulator.sv
// Sums groups of Q4.28 products and presents each rounded, saturated
// Q2.14 sum on a valid/ready register. The input never stalls; results
// that cannot be stored are dropped and flagged.
module opti_product_accumulator
    import opti_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int ACC_W     = ACC_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] p_in,
    input  logic        last_in,
    output logic [15:0] y,
    output logic        y_valid,
    input  logic        y_ready,
    output logic        y_sat,
    output logic        err_ovf,
    output logic        err_terms,
    input  logic        clr_err
);

    localparam int CNT_W = $clog2(MAX_TERMS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TERMS - 1);

    logic signed [ACC_W-1:0] acc_r;
    logic        [CNT_W-1:0] cnt_r;
    logic signed [ACC_W-1:0] sum_q_r;
    logic                    sum_v_r;
    logic        [15:0]      y_r;
    logic                    y_valid_r;
    logic                    y_sat_r;
    logic                    err_ovf_r;
    logic                    err_terms_r;

    logic signed [ACC_W-1:0] p_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    at_limit_s;
    logic                    close_s;
    logic                    terms_hit_s;
    logic        [15:0]      y_next_s;
    logic                    sat_s;
    logic                    load_s;
    logic                    drop_s;

    // The first product of a group ignores whatever acc still holds
    assign p_ext_s     = {{(ACC_W-32){p_in[31]}}, p_in};
    assign sum_s       = ((cnt_r == {CNT_W{1'b0}}) ? {ACC_W{1'b0}} : acc_r) + p_ext_s;
    assign at_limit_s  = (cnt_r == CNT_LAST);
    assign close_s     = valid_in && (last_in || at_limit_s);
    assign terms_hit_s = valid_in && at_limit_s && !last_in;

    assign load_s = sum_v_r && (!y_valid_r || y_ready);
    assign drop_s = sum_v_r && y_valid_r && !y_ready;

    opti_round_sat #(
        .IN_W  (ACC_W),
        .SHIFT (Q28_FRAC_BITS - Q15_FRAC_BITS)
    ) u_round_sat (
        .sum_q  (sum_q_r),
        .y_next (y_next_s),
        .sat    (sat_s)
    );

    // Accumulate products and hand each closed group to the requantizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            sum_q_r <= {ACC_W{1'b0}};
            sum_v_r <= 1'b0;
        end else if (valid_in) begin
            if (close_s) begin
                sum_q_r <= sum_s;
                sum_v_r <= 1'b1;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                acc_r   <= sum_s;
                cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                sum_v_r <= 1'b0;
            end
        end else begin
            sum_v_r <= 1'b0;
        end
    end

    // Output register: load takes priority, a bare handshake empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r       <= 16'h0000;
            y_valid_r <= 1'b0;
            y_sat_r   <= 1'b0;
        end else if (load_s) begin
            y_r       <= y_next_s;
            y_sat_r   <= sat_s;
            y_valid_r <= 1'b1;
        end else if (y_valid_r && y_ready) begin
            y_valid_r <= 1'b0;
        end
    end

    // Sticky error flags; a setting event beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_r   <= 1'b0;
            err_terms_r <= 1'b0;
        end else begin
            if (drop_s) begin
                err_ovf_r <= 1'b1;
            end else if (clr_err) begin
                err_ovf_r <= 1'b0;
            end
            if (terms_hit_s) begin
                err_terms_r <= 1'b1;
            end else if (clr_err) begin
                err_terms_r <= 1'b0;
            end
        end
    end

    assign y         = y_r;
    assign y_valid   = y_valid_r;
    assign y_sat     = y_sat_r;
    assign err_ovf   = err_ovf_r;
    assign err_terms = err_terms_r;

endmodule
